// File: rtl/tx_frame_builder.sv
// tx_frame_builder: builds 32-bit {payload, header} frames for the GTX TX
// datapath. Payloads are buffered in a small FIFO behind a valid/ready
// handshake; an FSM runs a training phase, inserts idle frames whenever the
// FIFO is empty, and the output stream can be slipped one bit at a time.
//
// Handshake: a payload transfers on any cycle where frame_valid && frame_ready.
// frame_ready is !full of the registered FIFO count (held low during rst) and
// never depends on frame_valid.
//
// Optional build macro PRBS_IDLE_EN: idle frames sent in RUN carry a PRBS7
// payload (x^7+x^6+1, seed 7'h7F, 30 bits per frame) instead of IDLE_PAYLOAD.
`timescale 1ns/1ps

module tx_frame_builder #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          TRAIN_FRAMES = 64,
  parameter logic [29:0] IDLE_PAYLOAD = 30'h0000F00F,
  parameter logic [1:0]  HDR_DATA     = 2'b01,
  parameter logic [1:0]  HDR_IDLE     = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic        train_req,
  input  logic        shift_fr_later,
  output logic [31:0] txdata,
  output logic        training,
  output logic [4:0]  shift_count,
  output logic [15:0] data_frames
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE_RST, TRAIN, RUN} state_t;

  state_t        state_q;
  logic [15:0]   train_cnt_q;
  logic [31:0]   prev_word_q;
  logic [29:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          full, empty, push, pop;
  logic [31:0]   cur_word, slip_word;
  logic [5:0]    rsh;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign frame_ready = !rst && !full;
  assign push        = frame_valid && frame_ready;
  // A train_req cycle never pops, so queued payloads survive retraining.
  assign pop         = (state_q == RUN) && !train_req && !empty;
  assign training    = (state_q == TRAIN);

`ifdef PRBS_IDLE_EN
  logic [6:0]  lfsr_q, lfsr_d;
  logic [29:0] prbs_payload;
  logic        idle_adv;

  // Advance the PRBS7 generator by 30 bits; bit 0 is the first bit produced.
  function automatic logic [36:0] prbs30(input logic [6:0] s_in);
    logic [6:0]  s;
    logic [29:0] p;
    s = s_in;
    p = '0;
    for (int i = 0; i < 30; i++) begin
      p[i] = s[6] ^ s[5];
      s    = {s[5:0], s[6] ^ s[5]};
    end
    return {s, p};
  endfunction

  assign idle_adv = (state_q == RUN) && !train_req && !pop;

  // Next PRBS state and payload for the current idle frame.
  always_comb begin
    {lfsr_d, prbs_payload} = prbs30(lfsr_q);
  end

  // LFSR steps only when a RUN idle frame actually uses its payload.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 7'h7F;
    else if (idle_adv) lfsr_q <= lfsr_d;
  end
`endif

  // Form the word for this cycle: popped data, or an idle/training word.
  always_comb begin
    cur_word = {IDLE_PAYLOAD, HDR_IDLE};
    if (pop) begin
      cur_word = {mem_q[rd_ptr_q], HDR_DATA};
    end
`ifdef PRBS_IDLE_EN
    else if (idle_adv) begin
      cur_word = {prbs_payload, HDR_IDLE};
    end
`endif
  end

  // Bit slip: take bits [63-k:32-k] of {cur_word, prev_word}; k=0 gives cur_word.
  always_comb begin
    rsh       = 6'd32 - {1'b0, shift_count};
    slip_word = (cur_word << shift_count) | (prev_word_q >> rsh);
  end

  // Payload FIFO: write on accept, read on pop, flushed by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= frame_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Control FSM with registered outputs, counters and the slipped TX word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE_RST;
      train_cnt_q <= '0;
      prev_word_q <= '0;
      txdata      <= '0;
      shift_count <= '0;
      data_frames <= '0;
    end else begin
      prev_word_q <= cur_word;
      txdata      <= slip_word;
      if (shift_fr_later) shift_count <= shift_count + 1'b1;
      if (pop) data_frames <= data_frames + 1'b1;
      case (state_q)
        IDLE_RST: begin
          state_q     <= TRAIN;
          train_cnt_q <= '0;
        end
        TRAIN: begin
          if (train_req) begin
            train_cnt_q <= '0;
          end else if (train_cnt_q == 16'(TRAIN_FRAMES - 1)) begin
            state_q <= RUN;
          end else begin
            train_cnt_q <= train_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (train_req) begin
            state_q     <= TRAIN;
            train_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE_RST;
      endcase
    end
  end

endmodule
